// File: rtl/ecc_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ecc_apb_initiator
// Description : APB requester that runs one ECC_ENC_DEC operation per request.
//               It writes DATA_IN, CODEWORD_WIDTH and NOISE, then CTRL. It then
//               waits for operation_done, or for a timeout, and returns the
//               captured result on a one-cycle response pulse.
//               The optional macro APB_READBACK_EN adds a read of each
//               configuration register right after it is written. A mismatch
//               sets the sticky rb_error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_apb_initiator #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  // Operation request
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [1:0]                 op_ctrl,
  input  logic [AMBA_WORD-1:0]       op_data,
  input  logic [1:0]                 op_width,
  input  logic [AMBA_WORD-1:0]       op_noise,
  // Operation response
  output logic                       res_valid,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_num_err,
  output logic                       res_timeout,
  output logic                       rb_error,
  // APB requester
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  // Slave status
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  // Register offsets inside the ECC_ENC_DEC block
  localparam logic [7:0] C_ADDR_CTRL  = 8'h00;
  localparam logic [7:0] C_ADDR_DATA  = 8'h04;
  localparam logic [7:0] C_ADDR_WIDTH = 8'h08;
  localparam logic [7:0] C_ADDR_NOISE = 8'h0C;

  // Index of the final transfer (always the CTRL write)
`ifdef APB_READBACK_EN
  localparam logic [2:0] C_LAST_STEP = 3'd6;
`else
  localparam logic [2:0] C_LAST_STEP = 3'd3;
`endif

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_step;
  logic [2:0]            w_step_next;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_next;
  logic                  r_ready;

  // Latched request fields
  logic [1:0]            r_ctrl;
  logic [1:0]            r_width;
  logic [AMBA_WORD-1:0]  r_data;
  logic [AMBA_WORD-1:0]  r_noise;

  // Result holding registers
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [1:0]            r_res_num_err;
  logic                  r_res_timeout;

  // Decoded current transfer
  logic [7:0]            w_offset;
  logic                  w_write;
  logic [AMBA_WORD-1:0]  w_value;

  logic                  w_bus;
  logic                  w_accept;
  logic                  w_done_hit;
  logic                  w_timeout_hit;

  assign w_accept      = op_valid && r_ready;
  assign w_bus         = (r_state == S_SETUP) || (r_state == S_ACCESS);
  // A done in the same cycle as the timeout takes priority
  assign w_done_hit    = (r_state == S_WAIT_DONE) && operation_done;
  assign w_timeout_hit = (r_state == S_WAIT_DONE) && !operation_done &&
                         ((r_cnt + 8'd1) == C_TIMEOUT);

  // Decode the step index into address, direction and associated value
  always_comb begin
    w_offset = C_ADDR_CTRL;
    w_write  = 1'b1;
    w_value  = AMBA_WORD'(r_ctrl);
`ifdef APB_READBACK_EN
    // Even steps write and odd steps read back the register just written
    w_write = ~r_step[0];
    case (r_step)
      3'd0, 3'd1: begin
        w_offset = C_ADDR_DATA;
        w_value  = r_data;
      end
      3'd2, 3'd3: begin
        w_offset = C_ADDR_WIDTH;
        w_value  = AMBA_WORD'(r_width);
      end
      3'd4, 3'd5: begin
        w_offset = C_ADDR_NOISE;
        w_value  = r_noise;
      end
      default: begin
        w_offset = C_ADDR_CTRL;
        w_value  = AMBA_WORD'(r_ctrl);
      end
    endcase
`else
    case (r_step)
      3'd0: begin
        w_offset = C_ADDR_DATA;
        w_value  = r_data;
      end
      3'd1: begin
        w_offset = C_ADDR_WIDTH;
        w_value  = AMBA_WORD'(r_width);
      end
      3'd2: begin
        w_offset = C_ADDR_NOISE;
        w_value  = r_noise;
      end
      default: begin
        w_offset = C_ADDR_CTRL;
        w_value  = AMBA_WORD'(r_ctrl);
      end
    endcase
`endif
  end

  // The bus outputs come from registered state, so an async reset idles the bus at once
  assign PSEL    = w_bus;
  assign PENABLE = (r_state == S_ACCESS);
  assign PWRITE  = w_bus && w_write;
  assign PADDR   = w_bus ? AMBA_ADDR_WIDTH'(w_offset) : '0;
  assign PWDATA  = (w_bus && w_write) ? w_value : '0;

  assign op_ready    = r_ready;
  assign res_valid   = (r_state == S_RESP);
  assign res_data    = r_res_data;
  assign res_num_err = r_res_num_err;
  assign res_timeout = r_res_timeout;

  // Next-state, step and wait-counter logic
  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_cnt_next   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SETUP;
          w_step_next  = '0;
        end
      end
      S_SETUP: begin
        w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_step == C_LAST_STEP) begin
          w_state_next = S_WAIT_DONE;
        end else begin
          // Back-to-back: the next SETUP directly follows this ACCESS
          w_state_next = S_SETUP;
          w_step_next  = r_step + 3'd1;
        end
      end
      S_WAIT_DONE: begin
        w_cnt_next = r_cnt + 8'd1;
        if (w_done_hit || w_timeout_hit) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; ready is registered so it stays low while rst is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_cnt   <= w_cnt_next;
      r_ready <= (w_state_next == S_IDLE);
    end
  end

  // Latch the request fields on the accepting handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_width <= '0;
      r_data  <= '0;
      r_noise <= '0;
    end else if (w_accept) begin
      r_ctrl  <= op_ctrl;
      r_width <= op_width;
      r_data  <= op_data;
      r_noise <= op_noise;
    end
  end

  // Capture the slave result, or zeros on timeout; held until the next RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_data    <= '0;
      r_res_num_err <= '0;
      r_res_timeout <= 1'b0;
    end else if (w_done_hit) begin
      r_res_data    <= data_out;
      r_res_num_err <= num_of_errors;
      r_res_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      r_res_data    <= '0;
      r_res_num_err <= '0;
      r_res_timeout <= 1'b1;
    end
  end

`ifdef APB_READBACK_EN
  logic r_rb_error;

  // Sticky flag set when a readback returns something other than what was written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rb_error <= 1'b0;
    end else if ((r_state == S_ACCESS) && !w_write && (PRDATA != w_value)) begin
      r_rb_error <= 1'b1;
    end
  end

  assign rb_error = r_rb_error;
`else
  // Without readback the read-data bus has no consumer
  logic w_unused_prdata;
  assign w_unused_prdata = ^PRDATA;
  assign rb_error        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ecc_apb_initiator.md
Name: ecc_apb_initiator

Overview:
- APB initiator that drives one complete ECC encode/decode operation into the ECC_ENC_DEC register block. It is the requester side of the same bus that the slave and checker sit on.
- Accepts one operation request per handshake, writes the configuration registers and then CTRL, waits for operation_done, captures the result and returns it on a response port.
- Used as the bench stimulus engine and as the host-side bridge in system builds.

Parameters:
- AMBA_ADDR_WIDTH, 20, PADDR width
- AMBA_WORD, 32, PWDATA/PRDATA width
- DATA_WIDTH, 32, data_out / res_data width
- TIMEOUT_CYCLES, 16, max WAIT_DONE cycles before reporting a timeout (range 1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  operation request valid
- op_ready  out  1  initiator can accept a request
- op_ctrl  in  2  CTRL value: 0 encode, 1 decode, 2 full channel
- op_data  in  AMBA_WORD  DATA_IN value
- op_width  in  2  CODEWORD_WIDTH value
- op_noise  in  AMBA_WORD  NOISE value
- res_valid  out  1  one-cycle result pulse
- res_data  out  DATA_WIDTH  captured data_out
- res_num_err  out  2  captured num_of_errors
- res_timeout  out  1  qualifies res_valid: operation timed out
- rb_error  out  1  sticky readback mismatch flag (see Optional Feature)
- PADDR  out  AMBA_ADDR_WIDTH  APB address
- PWDATA  out  AMBA_WORD  APB write data
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction, 1 = write
- PRDATA  in  AMBA_WORD  APB read data
- data_out  in  DATA_WIDTH  slave result
- operation_done  in  1  slave completion flag
- num_of_errors  in  2  slave error count

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, rb_error cleared. Reset asserted mid-transfer drops PSEL/PENABLE in the same cycle; no partial result is reported.
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- op_ready = 1 only in IDLE.
- On op_valid && op_ready, all op_* fields are latched. op_valid while busy is not accepted and has no effect.
- Fixed write sequence: 0x04 DATA_IN = op_data; 0x08 CODEWORD_WIDTH = op_width zero-extended; 0x0C NOISE = op_noise; 0x00 CTRL = op_ctrl zero-extended. CTRL is always last.
- PADDR upper bits are always 0.
- Each transfer takes exactly 2 cycles (no PREADY):
  - SETUP: PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE valid.
  - ACCESS: PSEL=1, PENABLE=1, address and data held.
- Back-to-back transfers: ACCESS goes directly to SETUP, PSEL stays 1.
- Idle bus: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Latency: request accepted at edge 0; first SETUP in cycle 1; CTRL ACCESS in cycle 8; WAIT_DONE from cycle 9.
- WAIT_DONE:
  - An 8-bit counter increments each cycle.
  - operation_done=1 captures data_out and num_of_errors, then moves to RESP.
  - Counter == TIMEOUT_CYCLES with no done moves to RESP with res_timeout=1, res_data=0, res_num_err=0.
  - done and timeout in the same cycle: done wins.
- RESP: res_valid=1 for exactly one cycle, then IDLE. res_data, res_num_err and res_timeout hold until the next RESP.
- operation_done outside WAIT_DONE is ignored.
- A new request can be accepted in the cycle after RESP.

Optional Feature:
- Macro: APB_READBACK_EN.
- Defined:
  - Each of the three configuration writes is followed by a 2-cycle read (PWRITE=0) of the same address.
  - PRDATA is compared in ACCESS against the written value; a mismatch sets rb_error, which stays set until rst.
  - CTRL is not read back.
  - CTRL ACCESS moves to cycle 14.
- Not defined: no read transfers; rb_error tied to 0.

Test Plan:
- Reset mid-SETUP of the DATA_IN write -> PSEL=0, PENABLE=0, op_ready=0 while rst is high, op_ready=1 after release, res_valid never pulses.
- Request ctrl=0, data=0x0000_00A5, width=0, noise=0 -> APB writes 0x04=0xA5, 0x08=0, 0x0C=0, 0x00=0, each 2 cycles, no gaps. Slave done 3 cycles after the CTRL ACCESS with data_out=0x0000_05A5 -> res_valid one cycle later, res_data=0x5A5, res_num_err=0.
- Decode request; slave returns num_of_errors=1 and data_out=0x3C -> res_num_err=1, res_data=0x3C, res_timeout=0.
- operation_done never asserted, TIMEOUT_CYCLES=16 -> res_valid 16 cycles after WAIT_DONE entry with res_timeout=1 and res_data=0. op_valid held during the wait is accepted only after RESP.
- operation_done pulsed while in IDLE and during the NOISE write -> ignored; the result comes from the real done.
- With APB_READBACK_EN: slave returns PRDATA=0xFFFF_FFFF on the NOISE readback -> rb_error=1 and stays 1 across the next operation. Bus order is W04, R04, W08, R08, W0C, R0C, W00.
